// File: rtl/lfsr_sig_checker.sv
// lfsr_sig_checker: receive-side checker for the 4-bit LFSR signature generator.
// On start it regenerates the expected signature from the seed. It then
// deserialises the incoming LSB-first bit stream and reports match, mismatch
// or timeout.
module lfsr_sig_checker #(
  parameter int N_STEPS = 8,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] seed,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic [3:0] exp_word,
  output logic [3:0] rx_word,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic       timeout_err
);

  localparam int STEP_W = $clog2(N_STEPS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          exp_q, exp_d;
  logic [3:0]          rx_q, rx_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [2:0]          bit_q, bit_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                match_q, match_d;
  logic                tmo_q, tmo_d;
  logic [3:0]          rx_shift;
  logic [IDLE_W-1:0]   idle_inc;

  // Shift right; the new MSB is bit3 XOR bit1. All-zero is a fixed point.
  function automatic logic [3:0] lfsr_next(input logic [3:0] e);
    return {e[3] ^ e[1], e[3], e[2], e[1]};
  endfunction

  assign rx_shift = {ser_in, rx_q[3:1]};
  assign idle_inc = idle_q + 1'b1;

  // Next-state and datapath decode for the whole check sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    exp_d   = exp_q;
    rx_d    = rx_q;
    step_d  = step_q;
    bit_d   = bit_q;
    idle_d  = idle_q;
    match_d = match_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_GEN;
          exp_d   = seed;
          rx_d    = '0;
          step_d  = '0;
          bit_d   = '0;
          idle_d  = '0;
          match_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end

      S_GEN: begin
        exp_d  = lfsr_next(exp_q);
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (ser_valid) begin
          rx_d   = rx_shift;
          bit_d  = bit_q + 3'd1;
          idle_d = '0;
          if (bit_q == 3'd3) begin
            state_d = S_DONE;
            match_d = (rx_shift == exp_q);
            tmo_d   = 1'b0;
          end
        end else begin
          // The idle counter saturates so it can never wrap past the limit.
          if (idle_q != IDLE_MAX) begin
            idle_d = idle_inc;
          end
          if (idle_inc >= IDLE_MAX) begin
            state_d = S_DONE;
            match_d = 1'b0;
            tmo_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any check in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      rx_q    <= '0;
      step_q  <= '0;
      bit_q   <= '0;
      idle_q  <= '0;
      match_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      exp_q   <= exp_d;
      rx_q    <= rx_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      idle_q  <= idle_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
    end
  end

  assign exp_word    = exp_q;
  assign rx_word     = rx_q;
  assign busy        = (state_q == S_GEN) || (state_q == S_RECV);
  assign done        = (state_q == S_DONE);
  assign match       = match_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_lfsr_sig_checker.sv
// Scoreboard bench for lfsr_sig_checker. Stimulus pushes the expected result
// of each check, and a negedge monitor pops it when done rises.
module tb_lfsr_sig_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic [3:0] exp_word, rx_word;
  logic       busy, done, match, timeout_err;

  lfsr_sig_checker #(.N_STEPS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .ser_in(ser_in), .ser_valid(ser_valid),
    .exp_word(exp_word), .rx_word(rx_word), .busy(busy), .done(done),
    .match(match), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp_w;
    logic [3:0] rx_w;
    logic       m;
    logic       t;
    int         cyc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: on each rising done, compare the DUT result with the queue head.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".exp_word"}, 32'(exp_word), 32'(e.exp_w));
        check({e.name, ".rx_word"}, 32'(rx_word), 32'(e.rx_w));
        check({e.name, ".match"}, 32'(match), 32'(e.m));
        check({e.name, ".timeout_err"}, 32'(timeout_err), 32'(e.t));
        check({e.name, ".busy"}, 32'(busy), 32'd0);
        check({e.name, ".done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start, then spend the 8 GEN cycles; optionally toggle ser_valid meanwhile.
  task automatic start_check(input logic [3:0] s, input bit noisy);
    start = 1'b1;
    seed  = s;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ser_in    = 1'b1;
      ser_valid = noisy ? ~i[0] : 1'b0;
      step();
    end
    ser_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    step();
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input string name, input logic [3:0] bits, input int gap,
                           input logic [3:0] ew, input logic m);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        e.exp_w = ew; e.rx_w = bits; e.m = m; e.t = 1'b0;
        e.cyc = cyc + 1; e.name = name;
        q.push_back(e);
      end
      send_bit(bits[i]);
      if (i < 3) repeat (gap) step();
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !done; i++) step();
    check({name, ".done_reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    exp_t e;
    // Reset state.
    #2;
    check("rst.exp_word", 32'(exp_word), 32'd0);
    check("rst.rx_word", 32'(rx_word), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.match", 32'(match), 32'd0);
    check("rst.timeout_err", 32'(timeout_err), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Seed 1001 -> 8 steps -> 1100; LSB-first bits 0,0,1,1.
    start_check(4'b1001, 1'b0);
    check("t1.busy_recv", 32'(busy), 32'd1);
    check("t1.exp_after_gen", 32'(exp_word), 32'b1100);
    send_word("t1_match", 4'b1100, 0, 4'b1100, 1'b1);
    wait_done("t1");

    // Bits 1,0,1,1 -> rx 1101, mismatch.
    start_check(4'b1001, 1'b0);
    send_word("t2_mismatch", 4'b1101, 0, 4'b1100, 1'b0);
    wait_done("t2");

    // Three idle cycles between bits are tolerated.
    start_check(4'b1001, 1'b0);
    send_word("t3_gaps", 4'b1100, 3, 4'b1100, 1'b1);
    wait_done("t3");

    // Two bits then silence: timeout 16 cycles after the last bit.
    start_check(4'b1001, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    e.exp_w = 4'b1100; e.rx_w = 4'b0000; e.m = 1'b0; e.t = 1'b1;
    e.cyc = cyc + 16; e.name = "t4_timeout";
    q.push_back(e);
    wait_done("t4");

    // Start from DONE clears flags on the same edge.
    start = 1'b1;
    seed  = 4'b1001;
    step();
    start = 1'b0;
    check("t5.done_cleared", 32'(done), 32'd0);
    check("t5.tmo_cleared", 32'(timeout_err), 32'd0);
    check("t5.busy", 32'(busy), 32'd1);
    repeat (8) step();
    send_bit(1'b0);
    send_bit(1'b0);
    // Asynchronous reset mid-RECV abandons the check.
    #2;
    rst = 1'b0;
    #1;
    check("t5.rst_exp_word", 32'(exp_word), 32'd0);
    check("t5.rst_rx_word", 32'(rx_word), 32'd0);
    check("t5.rst_busy", 32'(busy), 32'd0);
    check("t5.rst_done", 32'(done), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Seed 0010 -> 8 steps (one full period plus one) -> 1001.
    start_check(4'b0010, 1'b0);
    send_word("t6_seed0010", 4'b1001, 0, 4'b1001, 1'b1);
    wait_done("t6");

    // Seed 0000 is a fixed point.
    start_check(4'b0000, 1'b0);
    send_word("t7_zero", 4'b0000, 0, 4'b0000, 1'b1);
    wait_done("t7");

    // Restart from DONE with ser_valid toggling through GEN: bits are ignored.
    start = 1'b1;
    seed  = 4'b1001;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ser_in    = 1'b1;
      ser_valid = ~i[0];
      step();
      if (i == 6) check("t8.exp_after_7", 32'(exp_word), 32'b1001);
    end
    ser_valid = 1'b0;
    check("t8.exp_after_8", 32'(exp_word), 32'b1100);
    check("t8.rx_untouched", 32'(rx_word), 32'd0);
    send_word("t8_noisy_gen", 4'b1100, 0, 4'b1100, 1'b1);
    wait_done("t8");

    // Extra bits in DONE are not captured.
    send_bit(1'b1);
    send_bit(1'b1);
    check("t8.rx_hold", 32'(rx_word), 32'b1100);
    check("t8.done_hold", 32'(done), 32'd1);

    repeat (3) step();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
